clk_gate_ctrl: RTL and testbench

Enable controller for the ALU clock gate: it generates the registered CLK_EN consumed by the gate cell that produces the ALU's gated clock. The block wakes the gated domain on request and acknowledges once the gated clock is stable. It keeps the clock running while the ALU is busy, and shuts it off after a programmable idle window. It sits between the system controller (requester) and the clock gate, in the always-on reference clock domain.

---
 rtl/clk_gate_ctrl.sv | 93 +++++++++
 tb/tb_clk_gate_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Enable controller for the ALU clock gate: wakes the gated domain on request,
// acknowledges once the clock is stable, and gates it off after an idle window.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       test_en,
  input  logic       REQ,
  input  logic       BUSY,
  output logic       ACK,
  output logic       CLK_EN,
  output logic [7:0] WAKE_COUNT
);

  typedef enum logic [1:0] {OFF, WAKE, ON, HOLD} state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             en_r;
  logic             rst_sync;

  // rst_sync blocks the first edge after reset release so release is synchronous
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= OFF;
      cnt        <= '0;
      en_r       <= 1'b0;
      ACK        <= 1'b0;
      WAKE_COUNT <= '0;
      rst_sync   <= 1'b1;
    end else if (rst_sync) begin
      rst_sync <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (REQ) begin
            state <= WAKE;
            en_r  <= 1'b1;
            cnt   <= WAKE_LOAD;
            if (WAKE_COUNT != 8'hFF) WAKE_COUNT <= WAKE_COUNT + 8'd1;
          end
        end
        WAKE: begin
          // Wake always completes; REQ and BUSY are ignored here
          if (cnt == '0) begin
            state <= ON;
            ACK   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ON: begin
          if (!REQ && !BUSY) begin
            ACK <= 1'b0;
            if (IDLE_CYCLES == 0) begin
              state <= OFF;
              en_r  <= 1'b0;
            end else begin
              state <= HOLD;
              cnt   <= IDLE_LOAD;
            end
          end
        end
        HOLD: begin
          // Clock never stopped, so a re-request returns straight to ON
          if (REQ || BUSY) begin
            state <= ON;
            ACK   <= 1'b1;
          end else if (cnt == '0) begin
            state <= OFF;
            en_r  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= OFF;
          en_r  <= 1'b0;
          ACK   <= 1'b0;
        end
      endcase
    end
  end

  assign CLK_EN = en_r | test_en;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: three instances cover default timing,
// a longer wake window, and immediate shutdown with no idle window.
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       test_en;
  logic       req  [3];
  logic       busy [3];
  logic       ack_o[3];
  logic       en_o [3];
  logic [7:0] wc_o [3];

  int vectors;
  int miscompares;
  int cyc;

  typedef struct {
    int    tgt;
    int    dut;
    string name;
    logic  ack;
    logic  en;
    int    wc;
  } exp_t;

  exp_t sb[$];

  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(1), .CNT_W(4)) u0 (
    .CLK(clk), .RST(rst), .test_en(test_en), .REQ(req[0]), .BUSY(busy[0]),
    .ACK(ack_o[0]), .CLK_EN(en_o[0]), .WAKE_COUNT(wc_o[0]));

  clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(3), .CNT_W(4)) u1 (
    .CLK(clk), .RST(rst), .test_en(test_en), .REQ(req[1]), .BUSY(busy[1]),
    .ACK(ack_o[1]), .CLK_EN(en_o[1]), .WAKE_COUNT(wc_o[1]));

  clk_gate_ctrl #(.IDLE_CYCLES(0), .WAKE_CYCLES(1), .CNT_W(4)) u2 (
    .CLK(clk), .RST(rst), .test_en(test_en), .REQ(req[2]), .BUSY(busy[2]),
    .ACK(ack_o[2]), .CLK_EN(en_o[2]), .WAKE_COUNT(wc_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic cmp(input string name, input int d, input logic a, input logic e, input int w);
    vectors++;
    if (ack_o[d] !== a || en_o[d] !== e || (w >= 0 && int'(wc_o[d]) != w)) begin
      miscompares++;
      $display("FAIL %s u%0d: got ack=%b clk_en=%b wake_count=%0d, want ack=%b clk_en=%b wake_count=%0d",
               name, d, ack_o[d], en_o[d], wc_o[d], a, e, w);
    end
  endtask

  // Expectation due after the off-th rising edge from now
  task automatic want(input int off, input int d, input string name,
                      input logic a, input logic e, input int w);
    exp_t x;
    x.tgt  = cyc + off;
    x.dut  = d;
    x.name = name;
    x.ack  = a;
    x.en   = e;
    x.wc   = w;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation whose edge has just occurred
  always @(posedge clk) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tgt <= cyc) begin
        if (sb[i].tgt == cyc) begin
          cmp(sb[i].name, sb[i].dut, sb[i].ack, sb[i].en, sb[i].wc);
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL %s u%0d: expectation for edge %0d not checked (now %0d)",
                   sb[i].name, sb[i].dut, sb[i].tgt, cyc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b0;
    test_en     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      busy[i] = 1'b0;
    end
    req[0] = 1'b1;
    #1 rst = 1'b1;
    #1;
    cmp("reset_state", 0, 1'b0, 1'b0, 0);
    test_en = 1'b1;
    #1;
    cmp("test_en_override_u0", 0, 1'b0, 1'b1, 0);
    cmp("test_en_override_u2", 2, 1'b0, 1'b1, 0);
    test_en = 1'b0;
    step(2);

    // Release with REQ already high: first edge is swallowed, then wake
    rst = 1'b0;
    want(1, 0, "release_no_move", 1'b0, 1'b0, 0);
    want(2, 0, "wake_clk_en", 1'b0, 1'b1, 1);
    want(3, 0, "wake_ack", 1'b1, 1'b1, 1);
    step(4);

    // Idle shutdown through HOLD
    req[0] = 1'b0;
    for (int i = 1; i <= 4; i++) want(i, 0, "hold_window", 1'b0, 1'b1, 1);
    want(5, 0, "idle_off", 1'b0, 1'b0, 1);
    step(5);

    req[0] = 1'b1;
    want(1, 0, "rewake_en", 1'b0, 1'b1, 2);
    want(2, 0, "rewake_ack", 1'b1, 1'b1, 2);
    step(2);

    // Re-request from HOLD after two idle edges
    req[0] = 1'b0;
    want(1, 0, "hold_enter", 1'b0, 1'b1, 2);
    want(2, 0, "hold_idle2", 1'b0, 1'b1, 2);
    step(2);
    req[0] = 1'b1;
    want(1, 0, "hold_rereq", 1'b1, 1'b1, 2);
    step(1);

    // BUSY alone keeps the clock on
    req[0]  = 1'b0;
    busy[0] = 1'b1;
    for (int i = 1; i <= 10; i++) want(i, 0, "busy_keep", 1'b1, 1'b1, 2);
    step(10);
    busy[0] = 1'b0;
    for (int i = 1; i <= 4; i++) want(i, 0, "busy_hold", 1'b0, 1'b1, 2);
    want(5, 0, "busy_off", 1'b0, 1'b0, 2);
    step(5);

    // Three-cycle wake with REQ dropped mid-wake
    req[1] = 1'b1;
    for (int i = 1; i <= 3; i++) want(i, 1, "wake3_pending", 1'b0, 1'b1, 1);
    want(4, 1, "wake3_ack", 1'b1, 1'b1, 1);
    want(5, 1, "wake3_hold", 1'b0, 1'b1, 1);
    want(8, 1, "wake3_hold_end", 1'b0, 1'b1, 1);
    want(9, 1, "wake3_off", 1'b0, 1'b0, 1);
    step(1);
    req[1] = 1'b0;
    step(8);

    // No idle window: straight from ON to OFF
    req[2] = 1'b1;
    want(1, 2, "idle0_wake", 1'b0, 1'b1, 1);
    want(2, 2, "idle0_ack", 1'b1, 1'b1, 1);
    step(2);
    req[2]  = 1'b0;
    busy[2] = 1'b1;
    for (int i = 1; i <= 3; i++) want(i, 2, "idle0_busy", 1'b1, 1'b1, 1);
    step(3);
    busy[2] = 1'b0;
    want(1, 2, "idle0_off", 1'b0, 1'b0, 1);
    step(1);

    // Saturation of the wake counter
    for (int i = 0; i < 300; i++) begin
      if (i == 253) want(1, 2, "sat_reach", 1'b0, 1'b1, 255);
      req[2] = 1'b1;
      step(2);
      req[2] = 1'b0;
      step(1);
    end
    want(1, 2, "sat_hold", 1'b0, 1'b0, 255);
    want(1, 0, "u0_quiet", 1'b0, 1'b0, 2);
    step(1);

    // Asynchronous reset in the middle of a wake
    req[0] = 1'b1;
    want(1, 0, "pre_abort", 1'b0, 1'b1, 3);
    step(1);
    #2 rst = 1'b1;
    #1;
    cmp("abort_u0", 0, 1'b0, 1'b0, 0);
    cmp("abort_u2", 2, 1'b0, 1'b0, 0);
    req[0] = 1'b0;
    step(1);
    rst = 1'b0;
    want(1, 0, "post_abort", 1'b0, 1'b0, 0);
    want(2, 0, "post_abort_idle", 1'b0, 1'b0, 0);
    step(3);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
